// File: rtl/frame_strobe_sequencer_if.sv
// Configuration word stream: valid/ready handshake carrying 32-bit words.
interface frame_strobe_sequencer_if;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;

  // Word source (testbench / upstream loader)
  modport master (
    output s_data,
    output s_valid,
    input  s_ready
  );

  // Word sink (sequencer)
  modport slave (
    input  s_data,
    input  s_valid,
    output s_ready
  );
endinterface

// File: rtl/frame_strobe_sequencer.sv
// Frame strobe sequencer: hunts for a sync word, decodes a column/frame/count
// header, loads NumRows row words per frame and pulses one strobe line per frame.
module frame_strobe_sequencer #(
  parameter int unsigned FrameBitsPerRow = 32,
  parameter int unsigned MaxFramesPerCol = 20,
  parameter int unsigned NumRows         = 2,
  parameter int unsigned NumColumns      = 4
) (
  input  logic                                    CLK,
  input  logic                                    RST,
  frame_strobe_sequencer_if.slave                 s_if,
  output logic [FrameBitsPerRow*NumRows-1:0]      FrameData,
  output logic [MaxFramesPerCol*NumColumns-1:0]   FrameStrobe,
  output logic                                    busy,
  output logic                                    err
);

  localparam int unsigned RowW    = FrameBitsPerRow;
  localparam int unsigned DataW   = FrameBitsPerRow * NumRows;
  localparam int unsigned StrobeW = MaxFramesPerCol * NumColumns;
  localparam int unsigned RowIdxW = (NumRows > 1) ? $clog2(NumRows) : 1;
  localparam logic [31:0] SyncWord = 32'hFAB0_FAB1;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_HEADER,
    ST_DATA,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD
  } state_e;

  state_e               state_q, state_d;
  logic [7:0]           col_q, col_d;
  logic [7:0]           frame_q, frame_d;
  logic [7:0]           count_q, count_d;
  logic [RowIdxW-1:0]   row_q, row_d;
  logic [DataW-1:0]     data_q, data_d;
  logic [StrobeW-1:0]   strobe_q, strobe_d;
  logic                 err_q, err_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;

  logic [7:0]           hdr_col;
  logic [7:0]           hdr_frame;
  logic [7:0]           hdr_count;
  logic [8:0]           frame_inc;
  logic [7:0]           count_dec;

  assign hdr_col   = s_if.s_data[31:24];
  assign hdr_frame = s_if.s_data[23:16];
  assign hdr_count = s_if.s_data[7:0];

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus header/row bookkeeping; words are only taken in HUNT/HEADER/DATA
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    frame_d   = frame_q;
    count_d   = count_q;
    row_d     = row_q;
    data_d    = data_q;
    err_d     = err_q;
    frame_inc = 9'(frame_q) + 9'd1;
    count_dec = count_q - 8'd1;

    case (state_q)
      ST_HUNT: begin
        if (s_if.s_valid && (s_if.s_data == SyncWord)) begin
          state_d = ST_HEADER;
        end
      end

      ST_HEADER: begin
        if (s_if.s_valid) begin
          if (hdr_count == 8'd0) begin
            state_d = ST_HUNT;
          end else if ((32'(hdr_col) >= NumColumns) ||
                       (32'(hdr_frame) >= MaxFramesPerCol)) begin
            err_d   = 1'b1;
            state_d = ST_HUNT;
          end else begin
            col_d   = hdr_col;
            frame_d = hdr_frame;
            count_d = hdr_count;
            row_d   = '0;
            state_d = ST_DATA;
          end
        end
      end

      ST_DATA: begin
        if (s_if.s_valid) begin
          for (int r = 0; r < NumRows; r++) begin
            if (row_q == RowIdxW'(r)) begin
              data_d[r*RowW +: RowW] = RowW'(s_if.s_data);
            end
          end
          if (row_q == RowIdxW'(NumRows - 1)) begin
            state_d = ST_SETUP;
          end else begin
            row_d = row_q + RowIdxW'(1);
          end
        end
      end

      ST_SETUP: begin
        state_d = ST_STROBE;
      end

      ST_STROBE: begin
        state_d = ST_HOLD;
      end

      ST_HOLD: begin
        count_d = count_dec;
        if (count_dec == 8'd0) begin
          state_d = ST_HUNT;
        end else begin
          frame_d = frame_inc[7:0];
          if (frame_inc == 9'(MaxFramesPerCol)) begin
            err_d   = 1'b1;
            state_d = ST_HUNT;
          end else begin
            row_d   = '0;
            state_d = ST_DATA;
          end
        end
      end

      default: begin
        state_d = ST_HUNT;
      end
    endcase
  end

  // Output decode from the upcoming state so every output lands in a flop
  always_comb begin
    strobe_d = '0;
    busy_d   = (state_d != ST_HUNT);
    ready_d  = (state_d == ST_HUNT) || (state_d == ST_HEADER) || (state_d == ST_DATA);
    if (state_d == ST_STROBE) begin
      for (int c = 0; c < NumColumns; c++) begin
        for (int f = 0; f < MaxFramesPerCol; f++) begin
          if ((col_q == 8'(c)) && (frame_q == 8'(f))) begin
            strobe_d[c*MaxFramesPerCol + f] = 1'b1;
          end
        end
      end
    end
  end

  // Datapath and output registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      col_q    <= '0;
      frame_q  <= '0;
      count_q  <= '0;
      row_q    <= '0;
      data_q   <= '0;
      strobe_q <= '0;
      err_q    <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      col_q    <= col_d;
      frame_q  <= frame_d;
      count_q  <= count_d;
      row_q    <= row_d;
      data_q   <= data_d;
      strobe_q <= strobe_d;
      err_q    <= err_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  assign FrameData   = data_q;
  assign FrameStrobe = strobe_q;
  assign busy        = busy_q;
  assign err         = err_q;
  assign s_if.s_ready = ready_q;

endmodule

// File: tb/tb_frame_strobe_sequencer.sv
// Scoreboard bench for frame_strobe_sequencer: loads frames through the word
// stream, queues the expected strobe/data pairs and checks them as strobes fire.
module tb_frame_strobe_sequencer;

  localparam int unsigned FB = 32;
  localparam int unsigned MF = 20;
  localparam int unsigned NR = 2;
  localparam int unsigned NC = 4;
  localparam int unsigned DW = FB * NR;
  localparam int unsigned SW = MF * NC;
  localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

  logic          CLK = 1'b0;
  logic          RST;
  logic [DW-1:0] FrameData;
  logic [SW-1:0] FrameStrobe;
  logic          busy;
  logic          err;

  frame_strobe_sequencer_if s_if ();

  frame_strobe_sequencer #(
    .FrameBitsPerRow (FB),
    .MaxFramesPerCol (MF),
    .NumRows         (NR),
    .NumColumns      (NC)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .s_if        (s_if),
    .FrameData   (FrameData),
    .FrameStrobe (FrameStrobe),
    .busy        (busy),
    .err         (err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [SW-1:0] strobe;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks;
  int   n_pass;
  bit   gaps;
  logic exp_err;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] hdr(input int unsigned col, input int unsigned frame,
                                      input int unsigned count);
    return {8'(col), 8'(frame), 8'h00, 8'(count)};
  endfunction

  // Every strobe cycle must match the oldest queued expectation
  always @(negedge CLK) begin
    if (FrameStrobe != '0) begin
      if (sb.size() == 0) begin
        chk("strobe_unexpected", 128'(FrameStrobe), 128'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("strobe_bits", 128'(FrameStrobe), 128'(mon_e.strobe));
        chk("frame_data", 128'(FrameData), 128'(mon_e.data));
      end
    end
  end

  task automatic send_word(input logic [31:0] w);
    int guard;
    int n;
    n = gaps ? int'($urandom_range(0, 3)) : 0;
    repeat (n) @(negedge CLK);
    s_if.s_data  = w;
    s_if.s_valid = 1'b1;
    guard = 0;
    while (s_if.s_ready !== 1'b1 && guard < 20) begin
      @(negedge CLK);
      guard++;
    end
    if (s_if.s_ready !== 1'b1) chk("ready_timeout", 128'(s_if.s_ready), 128'd1);
    @(negedge CLK);
    s_if.s_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int guard;
    guard = 0;
    while (busy !== 1'b0 && guard < 50) begin
      @(negedge CLK);
      guard++;
    end
    repeat (2) @(negedge CLK);
    chk({tag, "_busy"}, 128'(busy), 128'd0);
    chk({tag, "_err"}, 128'(err), 128'(exp_err));
    chk({tag, "_sb_empty"}, 128'(sb.size()), 128'd0);
  endtask

  // Sync + header + data frames; the model decides which strobes must appear
  task automatic load(input int unsigned col, input int unsigned frame, input int unsigned count,
                      input logic [31:0] w0, input logic [31:0] w1);
    logic [DW-1:0] d;
    logic [31:0]   w;
    exp_t          e;
    d = '0;
    send_word(SYNC);
    send_word(hdr(col, frame, count));
    if (count == 0) return;
    if (col >= NC || frame >= MF) begin
      exp_err = 1'b1;
      return;
    end
    for (int unsigned k = 0; k < count; k++) begin
      for (int unsigned r = 0; r < NR; r++) begin
        if (k == 0) w = (r == 0) ? w0 : w1;
        else w = $urandom;
        d[r*FB +: FB] = w;
        send_word(w);
      end
      e.strobe = '0;
      e.strobe[col*MF + frame + k] = 1'b1;
      e.data = d;
      sb.push_back(e);
      if (k != count - 1 && frame + k + 1 == MF) begin
        exp_err = 1'b1;
        break;
      end
    end
  endtask

  // One reset edge with a sync word presented, then check all outputs cleared
  task automatic do_reset(input string tag);
    RST          = 1'b1;
    s_if.s_data  = SYNC;
    s_if.s_valid = 1'b1;
    @(negedge CLK);
    RST          = 1'b0;
    s_if.s_valid = 1'b0;
    exp_err      = 1'b0;
    chk({tag, "_data"}, 128'(FrameData), 128'd0);
    chk({tag, "_strobe"}, 128'(FrameStrobe), 128'd0);
    chk({tag, "_err"}, 128'(err), 128'd0);
    chk({tag, "_busy"}, 128'(busy), 128'd0);
    chk({tag, "_ready"}, 128'(s_if.s_ready), 128'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    n_checks     = 0;
    n_pass       = 0;
    gaps         = 1'b0;
    exp_err      = 1'b0;
    RST          = 1'b1;
    s_if.s_valid = 1'b0;
    s_if.s_data  = '0;
    repeat (3) @(negedge CLK);
    do_reset("rst0");

    // Single frame: col 2 frame 5 -> strobe bit 45
    load(2, 5, 1, 32'hAAAA_AAAA, 32'h5555_5555);
    wait_idle("single");

    // Garbage before sync is discarded; a zero-count header loads nothing
    send_word(32'h1234_5678);
    send_word(32'hFAB0_FAB0);
    chk("hunt_busy", 128'(busy), 128'd0);
    load(1, 0, 0, 32'h0, 32'h0);
    send_word(32'hAAAA_AAAA);
    send_word(32'h5555_5555);
    wait_idle("count0");

    // Highest legal strobe line
    load(3, 19, 1, 32'h1357_9BDF, 32'h2468_ACE0);
    wait_idle("corner");

    // Header range errors set sticky err; later loads still work
    load(4, 0, 1, 32'h0, 32'h0);
    wait_idle("col_range");
    load(0, 20, 1, 32'h0, 32'h0);
    wait_idle("frame_range");
    load(0, 0, 2, 32'h0000_0001, 32'h0000_0002);
    wait_idle("after_err");

    // Burst running past the last frame line of column 0
    do_reset("rst1");
    load(0, 18, 3, 32'hC0DE_0018, 32'hC0DE_1018);
    wait_idle("burst");

    // Sync presented only during reset must not be taken
    do_reset("rst2");
    send_word(32'h0205_0001);
    send_word(32'hAAAA_AAAA);
    send_word(32'h5555_5555);
    wait_idle("rst_nosync");

    // Random valid gaps, sync word used as payload
    gaps = 1'b1;
    for (int i = 0; i < 6; i++) begin
      load($urandom_range(0, NC - 1), $urandom_range(0, MF - 3), $urandom_range(1, 3),
           SYNC, $urandom);
      wait_idle("gaps");
    end
    gaps = 1'b0;

    // Reset while waiting for row 1
    send_word(SYNC);
    send_word(hdr(1, 3, 1));
    send_word(32'hDEAD_BEEF);
    chk("mid_data_row0", 128'(FrameData[FB-1:0]), 128'(32'hDEAD_BEEF));
    do_reset("rst_data");
    load(1, 3, 1, 32'h0BAD_F00D, 32'hCAFE_BABE);
    wait_idle("after_rst_data");

    // Reset while the strobe is high; the second frame is abandoned
    send_word(SYNC);
    send_word(hdr(2, 7, 2));
    send_word(32'h1111_2222);
    send_word(32'h3333_4444);
    e.strobe = '0;
    e.strobe[2*MF + 7] = 1'b1;
    e.data = {32'h3333_4444, 32'h1111_2222};
    sb.push_back(e);
    @(negedge CLK);
    chk("strobe_before_rst", 128'(FrameStrobe), 128'(e.strobe));
    do_reset("rst_strobe");
    repeat (4) @(negedge CLK);
    chk("rst_strobe_sb_empty", 128'(sb.size()), 128'd0);
    load(0, 1, 1, 32'h5A5A_5A5A, 32'hA5A5_A5A5);
    wait_idle("after_rst_strobe");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
